// File: rtl/acl_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acl_poll_sequencer
// Description : Configures an SPI accelerometer, then polls its X/Y sample
//               registers on request through an external byte-level master.
// Revision    : 1.0  initial release
// ============================================================================
module acl_poll_sequencer #(
  parameter int         CS_GAP  = 4,
  parameter logic [7:0] PWR_VAL = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       cfg_req,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       spi_cs_n,
  output logic [7:0] acl_x,
  output logic [7:0] acl_y,
  output logic       acl_valid,
  output logic       cfg_done
);

  localparam int c_gap_w = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(CS_GAP - 1);

  localparam logic [7:0] c_cmd_write = 8'h0A;
  localparam logic [7:0] c_cmd_read  = 8'h0B;
  localparam logic [7:0] c_reg_pwr   = 8'h2D;
  localparam logic [7:0] c_reg_xdata = 8'h08;

  typedef enum logic [3:0] {
    S_GAP, S_CFG_CMD, S_CFG_ADDR, S_CFG_DATA, S_IDLE,
    S_RD_CMD, S_RD_ADDR, S_RD_X, S_RD_Y
  } state_t;

  state_t             r_state;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               r_cfg_pend;
  logic               r_poll_pend;
  logic               r_busy;
  logic [7:0]         r_x_hold;

  logic w_cfg_any;
  logic w_launch_rd;
  logic w_may_launch;

  assign w_cfg_any    = r_cfg_pend | cfg_req;
  assign w_launch_rd  = (r_poll_pend | tick) & cfg_done;
  assign w_may_launch = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap_cnt == c_gap_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_GAP;
      r_gap_cnt   <= '0;
      r_cfg_pend  <= 1'b1;
      r_poll_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_x_hold    <= 8'h00;
      spi_start   <= 1'b0;
      spi_tx      <= 8'h00;
      spi_cs_n    <= 1'b1;
      acl_x       <= 8'h00;
      acl_y       <= 8'h00;
      acl_valid   <= 1'b0;
      cfg_done    <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      acl_valid <= 1'b0;
      if (cfg_req) begin
        r_cfg_pend <= 1'b1;
        cfg_done   <= 1'b0;
      end
      if (tick) r_poll_pend <= 1'b1;

      // Later assignments in this block deliberately override the pend-set
      // above, so a request arriving on the launch cycle is consumed.
      if (w_may_launch) begin
        if (w_cfg_any) begin
          r_state    <= S_CFG_CMD;
          spi_cs_n   <= 1'b0;
          r_busy     <= 1'b0;
          r_cfg_pend <= 1'b0;
        end else if (w_launch_rd) begin
          r_state     <= S_RD_CMD;
          spi_cs_n    <= 1'b0;
          r_busy      <= 1'b0;
          r_poll_pend <= 1'b0;
        end else begin
          r_state <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
          S_CFG_CMD, S_RD_CMD: begin
            // First cycle of a transaction only lowers chip select.
            if (!r_busy) begin
              spi_start <= 1'b1;
              spi_tx    <= (r_state == S_CFG_CMD) ? c_cmd_write : c_cmd_read;
              r_busy    <= 1'b1;
            end else if (spi_done) begin
              spi_start <= 1'b1;
              spi_tx    <= (r_state == S_CFG_CMD) ? c_reg_pwr : c_reg_xdata;
              r_state   <= (r_state == S_CFG_CMD) ? S_CFG_ADDR : S_RD_ADDR;
            end
          end
          S_CFG_ADDR: if (spi_done) begin
            spi_start <= 1'b1;
            spi_tx    <= PWR_VAL;
            r_state   <= S_CFG_DATA;
          end
          S_RD_ADDR: if (spi_done) begin
            spi_start <= 1'b1;
            spi_tx    <= 8'h00;
            r_state   <= S_RD_X;
          end
          S_RD_X: if (spi_done) begin
            r_x_hold  <= spi_rx;
            spi_start <= 1'b1;
            spi_tx    <= 8'h00;
            r_state   <= S_RD_Y;
          end
          S_CFG_DATA, S_RD_Y: if (spi_done) begin
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
            spi_cs_n  <= 1'b1;
            r_busy    <= 1'b0;
            if (r_state == S_RD_Y) begin
              acl_x     <= r_x_hold;
              acl_y     <= spi_rx;
              acl_valid <= 1'b1;
            end else if (!cfg_req) begin
              cfg_done <= 1'b1;
            end
          end
          default: r_state <= S_GAP;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acl_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acl_poll_sequencer
// Description : Directed bench with an 8-cycle SPI byte-master model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_acl_poll_sequencer;

  localparam int c_gap = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       cfg_req = 1'b0;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic       spi_done = 1'b0;
  logic [7:0] spi_rx = 8'h00;
  logic       spi_cs_n;
  logic [7:0] acl_x;
  logic [7:0] acl_y;
  logic       acl_valid;
  logic       cfg_done;

  acl_poll_sequencer #(.CS_GAP(c_gap), .PWR_VAL(8'h02)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_req(cfg_req),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_done(spi_done), .spi_rx(spi_rx),
    .spi_cs_n(spi_cs_n), .acl_x(acl_x), .acl_y(acl_y), .acl_valid(acl_valid),
    .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  // Byte-master model and bus monitor, all on the falling edge.
  logic [7:0] tx_log[$];
  logic [7:0] rx_x = 8'h00;
  logic [7:0] rx_y = 8'h00;
  int stray_req = 0, stray_ack = 0;
  int bm_cnt = 0, byte_idx = 0, cur_idx = 0;
  logic bm_busy = 1'b0;
  int valid_cnt = 0, cs_viol = 0, hi_run = 0, min_gap = 1000;
  logic had_low = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      bm_busy  = 1'b0;
      spi_done = 1'b0;
      byte_idx = 0;
      hi_run   = hi_run + 1;
    end else begin
      spi_done = 1'b0;
      if (spi_cs_n) byte_idx = 0;
      if (bm_busy) begin
        bm_cnt = bm_cnt - 1;
        if (bm_cnt == 0) begin
          spi_done = 1'b1;
          spi_rx   = (cur_idx == 2) ? rx_x : (cur_idx == 3) ? rx_y : 8'hA5;
          bm_busy  = 1'b0;
        end
      end
      if (stray_req != stray_ack) begin
        spi_done  = 1'b1;
        spi_rx    = 8'h99;
        stray_ack = stray_req;
      end
      if (spi_start) begin
        tx_log.push_back(spi_tx);
        if (spi_cs_n) cs_viol = cs_viol + 1;
        cur_idx  = byte_idx;
        byte_idx = byte_idx + 1;
        bm_busy  = 1'b1;
        bm_cnt   = 8;
      end
      if (acl_valid) valid_cnt = valid_cnt + 1;
      if (spi_cs_n) begin
        hi_run = hi_run + 1;
      end else begin
        if (had_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        had_low = 1'b1;
        hi_run  = 0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected bytes packed MSB-first: byte 0 is the first byte sent.
  task automatic expect_log(input string tag, input int base, input int n, input logic [63:0] bytes);
    int got_n;
    got_n = tx_log.size() - base;
    check({tag, "_count"}, got_n, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < tx_log.size())
        check($sformatf("%s_byte%0d", tag, i), tx_log[base + i], bytes[(n - 1 - i) * 8 +: 8]);
    end
  endtask

  task automatic wait_quiet();
    int run;
    int budget;
    run = 0;
    budget = 0;
    while (run < 12 && budget < 2000) begin
      @(negedge clk);
      run    = (spi_cs_n && !bm_busy) ? run + 1 : 0;
      budget = budget + 1;
    end
    check("quiet_reached", (run >= 12), 1);
  endtask

  task automatic pulse(input logic do_tick, input logic do_cfg);
    @(negedge clk);
    tick    = do_tick;
    cfg_req = do_cfg;
    @(negedge clk);
    tick    = 1'b0;
    cfg_req = 1'b0;
  endtask

  int base;
  int vbase;
  int budget;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_start", spi_start, 0);
    check("rst_tx", spi_tx, 0);
    check("rst_acl_x", acl_x, 0);
    check("rst_acl_y", acl_y, 0);
    check("rst_valid", acl_valid, 0);
    check("rst_cfg_done", cfg_done, 0);

    // Configuration after reset release
    base = tx_log.size();
    rst = 1'b0;
    wait_quiet();
    expect_log("cfg", base, 3, 64'h0A2D02);
    check("cfg_done_set", cfg_done, 1);
    check("cfg_no_valid", valid_cnt, 0);

    // Single poll with IDLE launch timing
    rx_x = 8'h12;
    rx_y = 8'hF0;
    base = tx_log.size();
    vbase = valid_cnt;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("launch_cs_low", spi_cs_n, 0);
    check("launch_no_start", spi_start, 0);
    @(negedge clk);
    check("launch_start", spi_start, 1);
    check("launch_tx", spi_tx, 8'h0B);
    wait_quiet();
    expect_log("read", base, 4, 64'h0B080000);
    check("read_acl_x", acl_x, 8'h12);
    check("read_acl_y", acl_y, 8'hF0);
    check("read_valid_cnt", valid_cnt - vbase, 1);

    // Three ticks during a read coalesce into one more read
    rx_x = 8'h34;
    rx_y = 8'h56;
    base = tx_log.size();
    vbase = valid_cnt;
    pulse(1'b1, 1'b0);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      repeat (3) @(negedge clk);
    end
    wait_quiet();
    expect_log("coalesce", base, 8, 64'h0B0800000B080000);
    check("coalesce_valid_cnt", valid_cnt - vbase, 2);
    check("coalesce_acl_x", acl_x, 8'h34);
    check("coalesce_acl_y", acl_y, 8'h56);

    // Simultaneous tick and cfg_req in IDLE: config then read
    rx_x = 8'h9A;
    rx_y = 8'hBC;
    base = tx_log.size();
    vbase = valid_cnt;
    pulse(1'b1, 1'b1);
    check("both_cfg_done_clr", cfg_done, 0);
    repeat (20) @(negedge clk);
    check("both_cfg_done_mid", cfg_done, 0);
    wait_quiet();
    expect_log("both", base, 7, 64'h0A2D020B080000);
    check("both_cfg_done", cfg_done, 1);
    check("both_valid_cnt", valid_cnt - vbase, 1);
    check("both_acl_x", acl_x, 8'h9A);

    // Reset during RD_X
    rx_x = 8'h55;
    rx_y = 8'h66;
    base = tx_log.size();
    vbase = valid_cnt;
    pulse(1'b1, 1'b0);
    budget = 0;
    while ((tx_log.size() - base) < 3 && budget < 200) begin
      @(negedge clk);
      budget = budget + 1;
    end
    check("rdx_reached", ((tx_log.size() - base) >= 3), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_cs_n", spi_cs_n, 1);
    check("rst_mid_acl_x", acl_x, 0);
    check("rst_mid_acl_y", acl_y, 0);
    check("rst_mid_cfg_done", cfg_done, 0);
    base = tx_log.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_quiet();
    expect_log("rst_recfg", base, 3, 64'h0A2D02);
    check("rst_valid_cnt", valid_cnt - vbase, 0);
    check("rst_after_acl_x", acl_x, 0);

    // Tick before configuration completes is deferred
    rx_x = 8'h7F;
    rx_y = 8'h80;
    @(negedge clk);
    rst = 1'b1;
    base = tx_log.size();
    vbase = valid_cnt;
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b1, 1'b0);
    wait_quiet();
    expect_log("early_tick", base, 7, 64'h0A2D020B080000);
    check("early_acl_x", acl_x, 8'h7F);
    check("early_acl_y", acl_y, 8'h80);
    check("early_valid_cnt", valid_cnt - vbase, 1);

    // Stray spi_done while idle is ignored
    base = tx_log.size();
    vbase = valid_cnt;
    @(negedge clk);
    stray_req = stray_req + 1;
    repeat (20) @(negedge clk);
    check("stray_no_bytes", tx_log.size() - base, 0);
    check("stray_cs_n", spi_cs_n, 1);
    check("stray_valid_cnt", valid_cnt - vbase, 0);
    check("stray_acl_x", acl_x, 8'h7F);

    check("cs_low_at_start", cs_viol, 0);
    check("min_gap_ok", (min_gap >= c_gap), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
